// File: rtl/sprite_pkg.sv
// Shared defaults, colour type and swap-state encoding for the sprite palette lookup.
package sprite_pkg;
  localparam int NUM_PAL_DEF = 4;
  localparam int IDX_W_DEF   = 4;
  localparam int COLOR_W_DEF = 24;

  typedef logic [COLOR_W_DEF-1:0] color_t;

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Palette-select width; a single palette still needs one select bit.
  function automatic int sel_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction
endpackage

// File: rtl/sprite_palette_lut_if.sv
// Write, swap-control and lookup signals of the palette lookup, grouped for port lists.
interface sprite_palette_lut_if
  import sprite_pkg::*;
#(
  parameter int NUM_PAL = NUM_PAL_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) ();
  localparam int PW = sel_w(NUM_PAL);

  logic               i_wr_en;
  logic [PW-1:0]      i_wr_pal;
  logic [IDX_W-1:0]   i_wr_idx;
  logic [COLOR_W-1:0] i_wr_color;
  logic               i_swap_req;
  logic               i_frame_start;
  logic               i_rd_valid;
  logic [PW-1:0]      i_rd_pal;
  logic [IDX_W-1:0]   i_rd_idx;
  logic               o_rd_valid;
  logic [COLOR_W-1:0] o_color;
  logic               o_transparent;
  logic               o_swap_pending;
  logic               o_active_bank;

  modport master (
    output i_wr_en, i_wr_pal, i_wr_idx, i_wr_color, i_swap_req, i_frame_start,
    output i_rd_valid, i_rd_pal, i_rd_idx,
    input  o_rd_valid, o_color, o_transparent, o_swap_pending, o_active_bank
  );

  modport slave (
    input  i_wr_en, i_wr_pal, i_wr_idx, i_wr_color, i_swap_req, i_frame_start,
    input  i_rd_valid, i_rd_pal, i_rd_idx,
    output o_rd_valid, o_color, o_transparent, o_swap_pending, o_active_bank
  );
endinterface

// File: rtl/palette_bank.sv
// One palette storage bank: synchronous write, combinational read, entry 0 and
// out-of-range palettes are never stored and always read as 0.
module palette_bank
  import sprite_pkg::*;
#(
  parameter int NUM_PAL = NUM_PAL_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  localparam int PW     = sel_w(NUM_PAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [PW-1:0]      wpal,
  input  logic [IDX_W-1:0]   widx,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [PW-1:0]      rpal,
  input  logic [IDX_W-1:0]   ridx,
  output logic [COLOR_W-1:0] rdata
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [PW:0] NP_C = NUM_PAL[PW:0];

  logic [COLOR_W-1:0] mem_r [NUM_PAL][DEPTH];

  function automatic logic addr_ok(input logic [PW-1:0] pal, input logic [IDX_W-1:0] idx);
    return ({1'b0, pal} < NP_C) && (idx != '0);
  endfunction

  // Storage array with whole-bank clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_r[p][e] <= '0;
        end
      end
    end else if (we && addr_ok(wpal, widx)) begin
      mem_r[wpal][widx] <= wdata;
    end
  end

  assign rdata = addr_ok(rpal, ridx) ? mem_r[rpal][ridx] : '0;
endmodule

// File: rtl/sprite_palette_lut.sv
// Double-buffered sprite palette lookup: writes land in the shadow bank, a swap armed by
// i_swap_req takes effect on the next frame boundary, lookups return after two cycles.
module sprite_palette_lut
  import sprite_pkg::*;
#(
  parameter int NUM_PAL = NUM_PAL_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input logic                i_clk,
  input logic                i_rst,
  sprite_palette_lut_if.slave bus
);
  localparam int PW = sel_w(NUM_PAL);
  localparam logic [PW:0] NP_C = NUM_PAL[PW:0];

  swap_state_t        state_r, state_next_s;
  logic               swap_now_s;
  logic               active_bank_r, pending_r;
  logic               we0_s, we1_s, rd_inval_s;
  logic [COLOR_W-1:0] rdata0_s, rdata1_s, rsel_s;
  logic               s1_valid_r, s1_trans_r, s2_valid_r, s2_trans_r;
  logic               out_valid_r, out_trans_r;
  logic [COLOR_W-1:0] s1_color_r, s2_color_r, out_color_r;

  // The shadow bank is the one not being read, judged before any swap on this edge
  assign we0_s = bus.i_wr_en & active_bank_r;
  assign we1_s = bus.i_wr_en & ~active_bank_r;

  palette_bank #(.NUM_PAL(NUM_PAL), .IDX_W(IDX_W), .COLOR_W(COLOR_W)) u_bank0 (
    .clk(i_clk), .rst(i_rst), .we(we0_s), .wpal(bus.i_wr_pal), .widx(bus.i_wr_idx),
    .wdata(bus.i_wr_color), .rpal(bus.i_rd_pal), .ridx(bus.i_rd_idx), .rdata(rdata0_s)
  );

  palette_bank #(.NUM_PAL(NUM_PAL), .IDX_W(IDX_W), .COLOR_W(COLOR_W)) u_bank1 (
    .clk(i_clk), .rst(i_rst), .we(we1_s), .wpal(bus.i_wr_pal), .widx(bus.i_wr_idx),
    .wdata(bus.i_wr_color), .rpal(bus.i_rd_pal), .ridx(bus.i_rd_idx), .rdata(rdata1_s)
  );

  assign rsel_s     = active_bank_r ? rdata1_s : rdata0_s;
  assign rd_inval_s = ({1'b0, bus.i_rd_pal} >= NP_C) || (bus.i_rd_idx == '0);

  // Swap FSM next-state and swap strobe
  always_comb begin
    state_next_s = state_r;
    swap_now_s   = 1'b0;
    case (state_r)
      SWAP_IDLE: begin
        if (bus.i_swap_req && bus.i_frame_start) begin
          swap_now_s = 1'b1;
        end else if (bus.i_swap_req) begin
          state_next_s = SWAP_PENDING;
        end else begin
          state_next_s = SWAP_IDLE;
        end
      end
      SWAP_PENDING: begin
        if (bus.i_frame_start) begin
          state_next_s = SWAP_IDLE;
          swap_now_s   = 1'b1;
        end else begin
          state_next_s = SWAP_PENDING;
        end
      end
      default: begin
        state_next_s = SWAP_IDLE;
      end
    endcase
  end

  // Swap FSM state, active bank and pending flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r       <= SWAP_IDLE;
      active_bank_r <= 1'b0;
      pending_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pending_r <= (state_next_s == SWAP_PENDING);
      if (swap_now_s) begin
        active_bank_r <= ~active_bank_r;
      end
    end
  end

  // Lookup pipeline; the bank read happens at sampling so later swaps cannot disturb it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_r  <= 1'b0;
      s1_trans_r  <= 1'b0;
      s1_color_r  <= '0;
      s2_valid_r  <= 1'b0;
      s2_trans_r  <= 1'b0;
      s2_color_r  <= '0;
      out_valid_r <= 1'b0;
      out_trans_r <= 1'b0;
      out_color_r <= '0;
    end else begin
      s1_valid_r  <= bus.i_rd_valid;
      s1_trans_r  <= bus.i_rd_valid & rd_inval_s;
      s1_color_r  <= (bus.i_rd_valid && !rd_inval_s) ? rsel_s : '0;
      s2_valid_r  <= s1_valid_r;
      s2_trans_r  <= s1_trans_r;
      s2_color_r  <= s1_color_r;
      out_valid_r <= s2_valid_r;
      out_trans_r <= s2_trans_r;
      out_color_r <= s2_color_r;
    end
  end

  assign bus.o_rd_valid     = out_valid_r;
  assign bus.o_transparent  = out_trans_r;
  assign bus.o_color        = out_color_r;
  assign bus.o_swap_pending = pending_r;
  assign bus.o_active_bank  = active_bank_r;
endmodule

// File: doc/sprite_palette_lut.md
SPRITE_PALETTE_LUT -- requirements
Module: sprite_palette_lut

Interface
REQ-001 SHALL have parameter NUM_PAL, default 4, number of palettes per bank.
REQ-002 SHALL have parameter IDX_W, default 4, colour-index width (2**IDX_W entries per palette).
REQ-003 SHALL have parameter COLOR_W, default 24, RGB colour width.
REQ-004 SHALL have ports: i_clk  in  1  sole clock; i_rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: i_wr_en  in  1  write strobe; i_wr_pal  in  clog2(NUM_PAL)  write palette; i_wr_idx  in  IDX_W  write entry; i_wr_color  in  COLOR_W  write data.
REQ-006 SHALL have ports: i_swap_req  in  1  request bank swap; i_frame_start  in  1  one-cycle frame-boundary pulse.
REQ-007 SHALL have ports: i_rd_valid  in  1  lookup request; i_rd_pal  in  clog2(NUM_PAL)  lookup palette; i_rd_idx  in  IDX_W  lookup index.
REQ-008 SHALL have ports: o_rd_valid  out  1  result valid; o_color  out  COLOR_W  looked-up colour; o_transparent  out  1  pixel transparent; o_swap_pending  out  1  swap armed, awaiting frame boundary; o_active_bank  out  1  bank currently read.

Function
REQ-009 SHALL hold two banks (0,1), each NUM_PAL x 2**IDX_W entries of COLOR_W bits; one is active (read), the other shadow (written).
REQ-010 SHALL write i_wr_color into shadow[i_wr_pal][i_wr_idx] on a cycle with i_wr_en=1; writes never touch the active bank.
REQ-011 SHALL ignore writes with i_wr_pal >= NUM_PAL or i_wr_idx = 0 (entry 0 reserved transparent, always reads 0).
REQ-012 SHALL perform lookups with fixed latency 2: request sampled at edge N, o_rd_valid/o_color/o_transparent valid after edge N+2; one lookup per cycle, fully pipelined, no stall.
REQ-013 SHALL select the bank for a lookup from o_active_bank at the sampling edge; a swap after sampling does not alter that in-flight result.
REQ-014 SHALL drive o_transparent=1 and o_color=0 when i_rd_idx=0 or i_rd_pal >= NUM_PAL; otherwise o_transparent=0 and o_color = stored entry.
REQ-015 SHALL hold o_color and o_transparent at 0 whenever o_rd_valid=0.
REQ-016 SHALL implement swap FSM states IDLE and PENDING; IDLE->PENDING on i_swap_req=1 without i_frame_start; PENDING->IDLE on i_frame_start=1, toggling o_active_bank on that edge.
REQ-017 SHALL, if i_swap_req and i_frame_start are both 1 in IDLE, swap on that same edge and remain IDLE.
REQ-018 SHALL ignore i_swap_req in PENDING (no double swap); i_frame_start in IDLE without request has no effect.
REQ-019 SHALL, on a write coinciding with a swap edge, write into the pre-swap shadow bank (the bank that becomes active).
REQ-020 SHALL drive o_swap_pending=1 exactly while in PENDING.

Reset
REQ-021 SHALL, on i_rst=1 asynchronously: clear all entries of both banks to 0, set o_active_bank=0, FSM=IDLE, o_swap_pending=0, clear pipeline so o_rd_valid=0, o_color=0, o_transparent=0.
REQ-022 SHALL discard in-flight lookups and pending swaps on reset mid-operation; first valid result appears 2 cycles after first post-reset request.

Structure
REQ-023 SHALL take defaults for NUM_PAL/IDX_W/COLOR_W, the colour typedef and the swap-state enum from shared package sprite_pkg.
REQ-024 SHALL instantiate sub-module palette_bank twice (one storage bank: synchronous write port, combinational read port), bank-select and FSM in the top.

Verification
REQ-025 Write pal1 idx5=24'h917db6 to shadow, lookup pal1 idx5 before swap -> o_color=0, o_transparent=0 after 2 cycles.
REQ-026 i_swap_req, then i_frame_start 10 cycles later -> o_swap_pending=1 for those cycles, o_active_bank 0->1 on frame edge; lookup pal1 idx5 -> 24'h917db6.
REQ-027 Back-to-back lookups idx 0,3,15 on pal0 every cycle -> three consecutive o_rd_valid pulses, first with o_transparent=1, o_color=0.
REQ-028 Write idx0=24'hffffff and pal=NUM_PAL -> no storage change; lookup pal=NUM_PAL idx3 -> o_transparent=1, o_color=0.
REQ-029 i_swap_req and i_frame_start same cycle with write pal0 idx2=24'h2c1656 -> immediate swap, o_swap_pending stays 0, next lookup pal0 idx2 -> 24'h2c1656.
REQ-030 Assert i_rst during PENDING with lookups in flight -> o_rd_valid=0 next cycle, o_active_bank=0, all entries read 0.
